// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak squeeze types, sizes and digest-length helper
package keccak_pkg;

    localparam int ROW_SIZE       = 5;
    localparam int COL_SIZE       = 5;
    localparam int LANE_SIZE      = 64;
    localparam int MODE_SEL_WIDTH = 2;
    localparam int RATE_WIDTH     = 11;
    localparam int STATE_BITS     = ROW_SIZE * COL_SIZE * LANE_SIZE;

    typedef enum logic [MODE_SEL_WIDTH-1:0] {
        MODE_SHA3_256 = 2'd0,
        MODE_SHA3_512 = 2'd1,
        MODE_SHAKE128 = 2'd2,
        MODE_SHAKE256 = 2'd3
    } keccak_mode_e;

    typedef enum logic [1:0] {
        SQ_IDLE,
        SQ_LOAD,
        SQ_SEND,
        SQ_PERM
    } squeeze_state_e;

    typedef logic [7:0] byte_lane_t;

    typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] keccak_state_t;

    // SHA3 digests have a fixed size; SHAKE squeezes whatever was asked for.
    function automatic int unsigned digest_bytes(input logic [MODE_SEL_WIDTH-1:0] mode,
                                                 input int unsigned shake_len);
        case (mode)
            MODE_SHA3_256: return 32;
            MODE_SHA3_512: return 64;
            default:       return shake_len;
        endcase
    endfunction

endpackage

// File: rtl/keccak_rate_window.sv
// rtl/keccak_rate_window.sv - selects one output beat from the rate at a byte offset
module keccak_rate_window
    import keccak_pkg::*;
#(
    parameter int DWIDTH    = 256,
    parameter int LEN_WIDTH = 16,
    parameter int NW        = $clog2(DWIDTH/8) + 1
) (
    input  keccak_state_t           state,
    input  logic [RATE_WIDTH-1:0]   rate_bytes,
    input  logic [RATE_WIDTH-1:0]   ofs,
    input  logic [LEN_WIDTH-1:0]    remaining,
    output logic [DWIDTH-1:0]       data,
    output logic [DWIDTH/8-1:0]     keep,
    output logic                    last,
    output logic [NW-1:0]           n
);

    localparam int DW_BYTES = DWIDTH / 8;
    localparam int MW       = LEN_WIDTH + 1;

    logic [STATE_BITS-1:0]          lin;
    logic [DWIDTH-1:0]              window;
    byte_lane_t [DW_BYTES-1:0]      beat;
    logic [MW-1:0]                  room;
    logic [MW-1:0]                  m;

    // Lane i = x + 5y sits at state[x][y]; lanes are little-endian byte streams.
    for (genvar i = 0; i < ROW_SIZE * COL_SIZE; i++) begin : g_lane
        assign lin[i*LANE_SIZE +: LANE_SIZE] = state[i % ROW_SIZE][i / ROW_SIZE];
    end

    assign window = DWIDTH'(lin >> {ofs, 3'b000});

    always_comb begin
        room = MW'(rate_bytes) - MW'(ofs);
        m    = MW'(DW_BYTES);
        if (room < m) m = room;
        if (MW'(remaining) < m) m = MW'(remaining);
        for (int j = 0; j < DW_BYTES; j++) begin
            keep[j] = (MW'(j) < m);
            beat[j] = keep[j] ? window[j*8 +: 8] : 8'h00;
        end
    end

    assign data = beat;
    assign n    = NW'(m);
    assign last = (MW'(remaining) == m);

endmodule

// File: rtl/keccak_squeeze_stream.sv
// rtl/keccak_squeeze_stream.sv - streams the squeezed Keccak rate out as AXI-Stream beats
module keccak_squeeze_stream
    import keccak_pkg::*;
#(
    parameter int DWIDTH    = 256,
    parameter int LEN_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  keccak_state_t               state_array_i,
    input  logic [MODE_SEL_WIDTH-1:0]   keccak_mode_i,
    input  logic [RATE_WIDTH-1:0]       rate_i,
    input  logic [LEN_WIDTH-1:0]        out_len_i,
    input  logic                        start_i,
    input  logic                        abort_i,
    output logic                        perm_req_o,
    input  logic                        perm_done_i,
    output logic [DWIDTH-1:0]           m_tdata_o,
    output logic [DWIDTH/8-1:0]         m_tkeep_o,
    output logic                        m_tvalid_o,
    input  logic                        m_tready_i,
    output logic                        m_tlast_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int DW_BYTES = DWIDTH / 8;
    localparam int NW       = $clog2(DW_BYTES) + 1;

    squeeze_state_e             fsm;
    logic [RATE_WIDTH-1:0]      ofs;
    logic [RATE_WIDTH-1:0]      rate_bytes;
    logic [LEN_WIDTH-1:0]       remaining;
    logic [LEN_WIDTH-1:0]       start_total;
    logic [DWIDTH-1:0]          win_data;
    logic [DW_BYTES-1:0]        win_keep;
    logic                       win_last;
    logic [NW-1:0]              win_n;

    assign start_total = LEN_WIDTH'(digest_bytes(keccak_mode_i, 32'(out_len_i)));
    assign busy_o      = (fsm != SQ_IDLE);

    keccak_rate_window #(
        .DWIDTH    (DWIDTH),
        .LEN_WIDTH (LEN_WIDTH),
        .NW        (NW)
    ) u_window (
        .state      (state_array_i),
        .rate_bytes (rate_bytes),
        .ofs        (ofs),
        .remaining  (remaining),
        .data       (win_data),
        .keep       (win_keep),
        .last       (win_last),
        .n          (win_n)
    );

    // ofs/remaining always point past the beat currently held on the bus, so the
    // window already shows the next beat when the handshake lands.
    always_ff @(posedge clk) begin
        if (rst || abort_i) begin
            fsm        <= SQ_IDLE;
            ofs        <= '0;
            rate_bytes <= '0;
            remaining  <= '0;
            m_tdata_o  <= '0;
            m_tkeep_o  <= '0;
            m_tvalid_o <= 1'b0;
            m_tlast_o  <= 1'b0;
            perm_req_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (fsm)
                SQ_IDLE: begin
                    if (start_i) begin
                        if (start_total == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            rate_bytes <= rate_i >> 3;
                            remaining  <= start_total;
                            ofs        <= '0;
                            fsm        <= SQ_LOAD;
                        end
                    end
                end
                SQ_LOAD: begin
                    m_tdata_o  <= win_data;
                    m_tkeep_o  <= win_keep;
                    m_tlast_o  <= win_last;
                    m_tvalid_o <= 1'b1;
                    ofs        <= ofs + RATE_WIDTH'(win_n);
                    remaining  <= remaining - LEN_WIDTH'(win_n);
                    fsm        <= SQ_SEND;
                end
                SQ_SEND: begin
                    if (m_tready_i) begin
                        if (remaining == '0) begin
                            m_tvalid_o <= 1'b0;
                            done_o     <= 1'b1;
                            fsm        <= SQ_IDLE;
                        end else if (ofs == rate_bytes) begin
                            m_tvalid_o <= 1'b0;
                            perm_req_o <= 1'b1;
                            fsm        <= SQ_PERM;
                        end else begin
                            m_tdata_o  <= win_data;
                            m_tkeep_o  <= win_keep;
                            m_tlast_o  <= win_last;
                            ofs        <= ofs + RATE_WIDTH'(win_n);
                            remaining  <= remaining - LEN_WIDTH'(win_n);
                        end
                    end
                end
                SQ_PERM: begin
                    if (perm_done_i) begin
                        perm_req_o <= 1'b0;
                        ofs        <= '0;
                        fsm        <= SQ_LOAD;
                    end
                end
                default: fsm <= SQ_IDLE;
            endcase
        end
    end

endmodule

// File: doc/keccak_squeeze_stream.md
Name: keccak_squeeze_stream

Overview:
Sequential, parametrised squeeze engine between the Keccak permutation core and an AXI-Stream output. It walks the rate portion of the state in beats of DWIDTH bits and emits exactly the requested number of output bytes. It requests further permutations by handshake when the rate is exhausted (SHAKE), and asserts tlast on the final byte. Output is registered and holds stable under backpressure.

Parameters:
DWIDTH, 256, output data width in bits; legal values 64, 128, 256.
LEN_WIDTH, 16, width of the requested output length in bytes.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
state_array_i  in  ROW_SIZE x COL_SIZE x LANE_SIZE  Keccak state; stable whenever the FSM is in LOAD or SEND
keccak_mode_i  in  MODE_SEL_WIDTH  SHA3_256, SHA3_512, SHAKE128, SHAKE256; sampled on start
rate_i  in  RATE_WIDTH  rate in bits (multiple of 64); sampled on start
out_len_i  in  LEN_WIDTH  requested bytes for SHAKE modes; sampled on start; ignored for SHA3 modes
start_i  in  1  one-cycle pulse: final absorb permutation done, begin squeezing
abort_i  in  1  synchronous flush to IDLE
perm_req_o  out  1  level; asks the core to permute the state
perm_done_i  in  1  one-cycle pulse: requested permutation complete
m_tdata_o  out  DWIDTH  output beat, byte 0 in bits [7:0]
m_tkeep_o  out  DWIDTH/8  valid bytes, contiguous from bit 0
m_tvalid_o  out  1  beat valid
m_tready_i  in  1  downstream ready
m_tlast_o  out  1  final beat of the digest
busy_o  out  1  FSM not in IDLE
done_o  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset: FSM to IDLE. All outputs are 0: tdata, tkeep, tvalid, tlast, perm_req_o, busy_o, done_o. Offset and remaining-byte counters are 0. Reset mid-stream drops tvalid on the next cycle with no completion of the beat.
- Total length set at start: SHA3_256 = 32 bytes, SHA3_512 = 64 bytes, SHAKE = out_len_i. Rate in bytes is rate_i >> 3.
- Linearisation: byte k of the rate is byte (k mod 8) of lane k/8. Lane index i = x + 5y maps to state_array_i[x][y].
- Beat size: n = min(DWIDTH/8, rate_bytes - ofs, remaining). Beats never span a permutation; a short beat at the rate end is legal and is not repacked.
- tkeep = (1<<n)-1. tlast = 1 iff remaining - n == 0.
- FSM states and transitions:
  - IDLE: on start_i with total > 0, go to LOAD. With total == 0, pulse done_o next cycle and stay in IDLE.
  - LOAD: register the beat at ofs, set tvalid, go to SEND. This is a 1-cycle bubble.
  - SEND: hold tdata/tkeep/tlast while tvalid && !tready. On handshake, ofs += n and remaining -= n, then:
    - remaining == 0: go to IDLE, drop tvalid, pulse done_o.
    - else ofs == rate_bytes: go to PERM, drop tvalid, raise perm_req_o.
    - else: load the next beat in the same cycle from the updated ofs, keep tvalid high, stay in SEND. This gives 1 beat/cycle within a block.
  - PERM: hold perm_req_o until perm_done_i, then ofs = 0, drop perm_req_o, go to LOAD.
- Latency: first tvalid 2 cycles after start_i (IDLE->LOAD->SEND). After perm_done_i, tvalid appears 2 cycles later.
- start_i while busy_o is ignored. perm_done_i outside PERM is ignored.
- abort_i has priority over all events except rst. It forces IDLE, clears tvalid, perm_req_o and the counters, and produces no done_o. It is an error-recovery path and may truncate an AXI beat.
- tvalid never falls without a handshake, except on rst or abort_i.
- Counter widths: ofs is RATE_WIDTH; remaining is LEN_WIDTH. The beat-size minimum is computed at LEN_WIDTH+1 bits so it cannot wrap.

Decomposition:
- keccak_pkg: add a function returning digest length for a mode, a squeeze FSM state enum, and a DW_BYTES-independent byte-lane type.
- One natural sub-module: keccak_rate_window (combinational; state, ofs, remaining -> data, keep, last, n). It is reused by LOAD and the back-to-back load path.

Test Plan:
- DWIDTH=256, SHA3_256, rate 1088, tready=1: start -> one beat 2 cycles later with tkeep all ones, tlast=1, done_o next cycle, perm_req_o never asserted.
- DWIDTH=256, SHA3_512, rate 576: two beats of 32 bytes back-to-back, tlast on beat 2, data = state bytes 0..63 in order.
- DWIDTH=256, SHAKE128, rate 1344, out_len 200:
  - First block: beats of 32,32,32,32,32,8 bytes; the 6th beat has tkeep=0xFF and tlast=0.
  - perm_req_o then stays high until perm_done_i (driven after 24 cycles).
  - Second block: one 32-byte beat with tlast=1.
- DWIDTH=64, SHAKE256, rate 1088, out_len 140, random tready: 17 full beats, then PERM, then one beat with tkeep=0x0F and tlast=1. tdata is stable during every stall.
- Abort and reset mid-stream with tready=0 on beat 3: abort_i -> next cycle tvalid=0, perm_req_o=0, busy_o=0, no done_o. Repeat with rst -> all outputs 0.
- Edge cases:
  - SHAKE with out_len 0 -> done_o pulse, no beats.
  - start_i while busy -> ignored.
  - perm_done_i in IDLE -> no effect.
